// File: rtl/bram_frame_writer.sv
// Raster pixel stream to BRAM port-A write strobes, row-major, with frame/error status.
// Optional ping-pong bank select enabled by defining BRAM_FRAME_WRITER_PINGPONG_EN.
module bram_frame_writer #(
    parameter int IM_WIDTH   = 320,
    parameter int IM_HEIGHT  = 240,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_enable,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_bank,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sof_err
);

    localparam int XW = $clog2(IM_WIDTH);
    localparam int YW = $clog2(IM_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IM_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IM_HEIGHT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [XW-1:0]           r_x;
    logic [XW-1:0]           w_x_nxt;
    logic [YW-1:0]           r_y;
    logic [YW-1:0]           w_y_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic                    w_wr;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic                    w_done;
    logic                    w_err_set;

    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_sof_err;

    // Next-state, position counters and write strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_addr_nxt  = r_addr;
        w_wr        = 1'b0;
        w_wr_addr   = r_addr;
        w_done      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_enable && in_sof) begin
                    w_wr        = 1'b1;
                    w_wr_addr   = '0;
                    w_x_nxt     = XW'(1);
                    w_y_nxt     = '0;
                    w_addr_nxt  = ADDR_WIDTH'(1);
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // A mid-frame sof restarts the frame from this very pixel
                if (in_enable && in_sof) begin
                    w_err_set   = 1'b1;
                    w_wr        = 1'b1;
                    w_wr_addr   = '0;
                    w_x_nxt     = XW'(1);
                    w_y_nxt     = '0;
                    w_addr_nxt  = ADDR_WIDTH'(1);
                    w_state_nxt = ST_WRITE;
                end else if (in_enable) begin
                    w_wr      = 1'b1;
                    w_wr_addr = r_addr;
                    if ((r_x == X_LAST) && (r_y == Y_LAST)) begin
                        w_done      = 1'b1;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_addr_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_x == X_LAST) begin
                        w_x_nxt    = '0;
                        w_y_nxt    = r_y + YW'(1);
                        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    end else begin
                        w_x_nxt    = r_x + XW'(1);
                        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    end
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
                w_addr_nxt  = '0;
            end
        endcase
    end

    // State, counters and registered port-A outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_addr       <= w_addr_nxt;
            r_wr_en      <= w_wr;
            r_busy       <= (w_state_nxt == ST_WRITE);
            r_frame_done <= w_done;
            r_sof_err    <= r_sof_err | w_err_set;
            if (w_wr) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= in_data;
            end
        end
    end

`ifdef BRAM_FRAME_WRITER_PINGPONG_EN
    logic r_bank;

    // Flip to the other bank once a complete frame has been written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= 1'b0;
        end else if (r_frame_done) begin
            r_bank <= ~r_bank;
        end else begin
            r_bank <= r_bank;
        end
    end

    assign wr_bank = r_bank;
`else
    assign wr_bank = 1'b0;
`endif

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_bram_frame_writer.sv
// Directed bench for bram_frame_writer using a reduced 8x4 frame.
module tb_bram_frame_writer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int DW   = 8;
    localparam int AW   = 17;
    localparam int NPIX = W * H;

    logic          clk;
    logic          rst_n;
    logic          in_enable;
    logic          in_sof;
    logic [DW-1:0] in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_bank;
    logic          busy;
    logic          frame_done;
    logic          sof_err;

    int n_cmp = 0;
    int n_bad = 0;

    bram_frame_writer #(
        .IM_WIDTH  (W),
        .IM_HEIGHT (H),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_enable (in_enable),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_bank   (wr_bank),
        .busy      (busy),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       sof;
        logic [7:0] d;
        logic       we;
        int         addr;
        logic [7:0] wd;
        logic       bsy;
        logic       dn;
        logic       err;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_bank(input int fidx);
`ifdef BRAM_FRAME_WRITER_PINGPONG_EN
        return fidx[0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] pix(input int p, input logic [7:0] seed);
        logic [7:0] v;
        v = p[7:0];
        return v ^ seed;
    endfunction

    task automatic step(input logic en, input logic sof, input logic [7:0] d);
        in_enable = en;
        in_sof    = sof;
        in_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input int addr, input logic [7:0] d,
                             input logic bsy, input logic dn, input logic err, input logic bank);
        chk($sformatf("%s wr_en", tag), 32'(wr_en), 32'(we));
        chk($sformatf("%s wr_addr", tag), 32'(wr_addr), addr);
        chk($sformatf("%s wr_data", tag), 32'(wr_data), 32'(d));
        chk($sformatf("%s busy", tag), 32'(busy), 32'(bsy));
        chk($sformatf("%s frame_done", tag), 32'(frame_done), 32'(dn));
        chk($sformatf("%s sof_err", tag), 32'(sof_err), 32'(err));
        chk($sformatf("%s wr_bank", tag), 32'(wr_bank), 32'(bank));
    endtask

    // Drives pixels start_p..NPIX-1, optionally with one idle cycle before every gap_mod-th pixel
    task automatic run_frame(input int start_p, input logic with_sof, input int gap_mod, input int fidx,
                             input logic err, input logic [7:0] seed);
        int dones;
        dones = 0;
        for (int p = start_p; p < NPIX; p++) begin
            if (gap_mod > 0 && (p % gap_mod) == 1) begin
                step(1'b0, 1'b0, 8'hEE);
                check_out($sformatf("f%0d gap%0d", fidx, p), 1'b0, p - 1, pix(p - 1, seed),
                          1'b1, 1'b0, err, exp_bank(fidx));
            end
            step(1'b1, with_sof && (p == start_p), pix(p, seed));
            check_out($sformatf("f%0d pix%0d", fidx, p), 1'b1, p, pix(p, seed),
                      p != NPIX - 1, p == NPIX - 1, err, exp_bank(fidx));
            dones += int'(frame_done);
        end
        step(1'b0, 1'b0, 8'h00);
        check_out($sformatf("f%0d idle", fidx), 1'b0, NPIX - 1, pix(NPIX - 1, seed),
                  1'b0, 1'b0, err, exp_bank(fidx + 1));
        chk($sformatf("f%0d done count", fidx), dones, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_enable = 1'b0;
        in_sof    = 1'b0;
        in_data   = 8'h00;

        // drop, sof, gap, two pixels, restart, one pixel
        tv[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 8'hA0, 1'b1, 0, 8'hA0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 8'h77, 1'b0, 0, 8'hA0, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 8'hA1, 1'b1, 1, 8'hA1, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 8'hA2, 1'b1, 2, 8'hA2, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 8'hB0, 1'b1, 0, 8'hB0, 1'b1, 1'b0, 1'b1};
        tv[6] = '{1'b1, 1'b0, 8'hB1, 1'b1, 1, 8'hB1, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(tv[i].en, tv[i].sof, tv[i].d);
            check_out($sformatf("vec%0d", i), tv[i].we, tv[i].addr, tv[i].wd,
                      tv[i].bsy, tv[i].dn, tv[i].err, 1'b0);
        end
        // Restarted frame continues from addr 2 and completes once
        run_frame(2, 1'b0, 0, 0, 1'b1, 8'h40);

        // Abort a frame with an asynchronous reset in the middle of a cycle
        for (int p = 0; p < 5; p++) begin
            step(1'b1, p == 0, pix(p, 8'h99));
            check_out($sformatf("pre-rst pix%0d", p), 1'b1, p, pix(p, 8'h99), 1'b1, 1'b0, 1'b1, exp_bank(1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async rst", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        in_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Pixels without sof are dropped
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'(i + 1));
            check_out($sformatf("drop%0d", i), 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        run_frame(0, 1'b1, 0, 0, 1'b0, 8'h00);
        run_frame(0, 1'b1, 0, 1, 1'b0, 8'h5A);
        run_frame(0, 1'b1, 3, 2, 1'b0, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
